// File: rtl/mem8x8_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem8x8_access_ctrl
//
// Sequencer and two-port round-robin arbiter in front of the 8x8 register
// memory. Requesters A and B each present one read or write request at a
// time. The controller grants one access, drives the memory strobes, address
// and write data, and returns read data to the requester that asked for it.
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x stable and
// holds it until it sees gnt_x high. On the edge that samples gnt_x = 1 it
// either drops req_x or presents its next request. Requests are only sampled
// in IDLE, so a change on req_x during ISSUE/RDWAIT has no effect until the
// next IDLE cycle, and a held request is never lost.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_x, we_x           request and direction (1 = write) for x in {a, b}
//   addr_x, wdata_x       word address and write data for requester x
//   gnt_x                 one-cycle pulse in the cycle x's access is issued
//   rdata_x, rvalid_x     last read data for x; rvalid_x pulses when updated
//   mem_we, mem_re        write / read strobes to the memory (never both)
//   mem_addr, mem_wdata   word address and write data to the memory
//   mem_rdata             memory read data, valid the cycle after mem_re
//   state_dbg             current FSM state (0 IDLE, 1 ISSUE, 2 RDWAIT)
//
// Timing from a request sampled in IDLE at edge t: gnt and strobe in cycle
// t+1; a write allows the next accept at edge t+2; a read returns rvalid in
// cycle t+3. Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module mem8x8_access_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_b_q, last_b_d;     // 1: B was granted last
  logic                lat_b_q, lat_b_d;       // access in flight belongs to B
  logic                lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;

  logic                gnt_a_q, gnt_a_d;
  logic                gnt_b_q, gnt_b_d;
  logic                rvalid_a_q, rvalid_a_d;
  logic                rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Arbitration: a lone request wins; under contention the requester that
  // was not granted last wins.
  logic                sel_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    sel_b     = req_b && !(req_a && last_b_q);
    sel_we    = sel_b ? we_b    : we_a;
    sel_addr  = sel_b ? addr_b  : addr_a;
    sel_wdata = sel_b ? wdata_b : wdata_a;
  end

  // Because outputs are registered, the values seen during ISSUE are loaded
  // on the accepting edge in IDLE, straight from the selected request.
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    lat_b_d     = lat_b_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          lat_b_d     = sel_b;
          lat_we_d    = sel_we;
          lat_addr_d  = sel_addr;
          last_b_d    = sel_b;
          gnt_a_d     = !sel_b;
          gnt_b_d     = sel_b;
          mem_we_d    = sel_we;
          mem_re_d    = !sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_we ? sel_wdata : '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lat_we_q) begin
          state_d = S_IDLE;
        end else begin
          // Address stays on the bus while the memory returns read data.
          mem_addr_d = lat_addr_q;
          state_d    = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        state_d = S_IDLE;
        if (lat_b_q) begin
          rdata_b_d  = mem_rdata;
          rvalid_b_d = 1'b1;
        end else begin
          rdata_a_d  = mem_rdata;
          rvalid_a_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;   // A wins the first contention
      lat_b_q     <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      lat_b_q     <= lat_b_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign state_dbg = state_q;

endmodule
